// File: rtl/soc_gpio_if.sv
// soc_gpio_if: register bus between a host and the soc_gpio block
interface soc_gpio_if;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  modport master (output addr, wdata, we, re, input rdata);
  modport slave  (input addr, wdata, we, re, output rdata);
endinterface

// File: rtl/soc_gpio.sv
// soc_gpio: LED output register, synchronized button inputs with rising-edge capture and masked interrupt; define GPIO_DEBOUNCE_EN to add per-bit debounce counters
module soc_gpio #(
  parameter int OUT_WIDTH = 9,
  parameter int IN_WIDTH = 8,
  parameter int DEBOUNCE_WIDTH = 4,
  parameter logic [DEBOUNCE_WIDTH-1:0] DEBOUNCE_VALUE = 4'd2
) (
  input  logic                 clk,
  input  logic                 rst,
  soc_gpio_if.slave            bus,
  output logic [OUT_WIDTH-1:0] leds,
  input  logic [IN_WIDTH-1:0]  buttons,
  output logic                 irq
);
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [IN_WIDTH-1:0]  s1_q, s1_d, stable_q, stable_d, edge_q, edge_d, mask_q, mask_d, clr;
  logic [31:0]          rdata_q, rdata_d;
  logic                 irq_q, irq_d;
  logic                 unused_bits;
`ifdef GPIO_DEBOUNCE_EN
  logic [IN_WIDTH-1:0]       s2_q, s2_d;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q [IN_WIDTH];
  logic [DEBOUNCE_WIDTH-1:0] cnt_d [IN_WIDTH];
  // accept a new level only after it has differed from the stable one for DEBOUNCE_VALUE cycles
  always_comb begin
    s2_d = s1_q;
    stable_d = stable_q;
    for (int i = 0; i < IN_WIDTH; i++) begin
      cnt_d[i] = (s2_q[i] == stable_q[i] || cnt_q[i] + DEBOUNCE_WIDTH'(1) >= DEBOUNCE_VALUE) ? '0 : cnt_q[i] + DEBOUNCE_WIDTH'(1);
      stable_d[i] = (s2_q[i] != stable_q[i] && cnt_q[i] + DEBOUNCE_WIDTH'(1) >= DEBOUNCE_VALUE) ? s2_q[i] : stable_q[i];
    end
  end
`else
  // without debounce the second synchronizer stage is the accepted level
  always_comb stable_d = s1_q;
`endif
  // register writes, rising-edge capture (set beats clear), interrupt and read mux on pre-write values
  always_comb begin
    s1_d = buttons;
    clr = (bus.we && bus.addr == 2'd2) ? bus.wdata[IN_WIDTH-1:0] : '0;
    edge_d = (edge_q & ~clr) | (stable_d & ~stable_q);
    out_d = (bus.we && bus.addr == 2'd0) ? bus.wdata[OUT_WIDTH-1:0] : out_q;
    mask_d = (bus.we && bus.addr == 2'd3) ? bus.wdata[IN_WIDTH-1:0] : mask_q;
    irq_d = |(edge_q & mask_q);
    rdata_d = !bus.re ? rdata_q :
              bus.addr == 2'd0 ? 32'(out_q) :
              bus.addr == 2'd1 ? 32'(stable_q) :
              bus.addr == 2'd2 ? 32'(edge_q) : 32'(mask_q);
  end
  // all state clears asynchronously so a pending debounce is discarded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      s1_q <= '0;
      stable_q <= '0;
      edge_q <= '0;
      mask_q <= '0;
      rdata_q <= '0;
      irq_q <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
      s2_q <= '0;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
`endif
    end else begin
      out_q <= out_d;
      s1_q <= s1_d;
      stable_q <= stable_d;
      edge_q <= edge_d;
      mask_q <= mask_d;
      rdata_q <= rdata_d;
      irq_q <= irq_d;
`ifdef GPIO_DEBOUNCE_EN
      s2_q <= s2_d;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= cnt_d[i];
`endif
    end
  end
  assign bus.rdata = rdata_q;
  assign leds = out_q;
  assign irq = irq_q;
  assign unused_bits = ^{bus.wdata, DEBOUNCE_VALUE};
endmodule

// File: doc/soc_gpio.md
SOC_GPIO -- requirements
Module: soc_gpio

Interface
REQ-001 Parameter OUT_WIDTH, default 9, number of LED output bits (1..32).
REQ-002 Parameter IN_WIDTH, default 8, number of button input bits (1..32).
REQ-003 Parameter DEBOUNCE_WIDTH, default 4, width of each per-bit debounce counter.
REQ-004 Parameter DEBOUNCE_VALUE, default 4'd2, stable-cycle count required to accept a new input level (1..2^DEBOUNCE_WIDTH-1).
REQ-005 Port clk  input  1  single system clock; all state on rising edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port addr  input  2  word register select: 0 OUT, 1 IN, 2 EDGE, 3 MASK.
REQ-008 Port wdata  input  32  write data.
REQ-009 Port we  input  1  write strobe, sampled on clk.
REQ-010 Port re  input  1  read strobe, sampled on clk.
REQ-011 Port rdata  output  32  read data, registered.
REQ-012 Port leds  output  OUT_WIDTH  driven directly from OUT register.
REQ-013 Port buttons  input  IN_WIDTH  asynchronous raw inputs.
REQ-014 Port irq  output  1  registered level interrupt.

Function
REQ-015 Each buttons bit SHALL pass a 2-flop synchronizer before any other logic.
REQ-016 Debounce per bit: sync==stable -> counter cleared; sync!=stable -> counter increments; counter reaching DEBOUNCE_VALUE -> stable<=sync, counter cleared same cycle.
REQ-017 A glitch shorter than DEBOUNCE_VALUE cycles SHALL NOT change stable.
REQ-018 Input-to-IN latency SHALL be 2 (sync) + DEBOUNCE_VALUE cycles.
REQ-019 EDGE bit SHALL set for one-cycle 0->1 transition of its stable bit; falling transitions ignored.
REQ-020 Write to EDGE SHALL clear bits where wdata is 1 (write-1-to-clear); zeros have no effect.
REQ-021 Simultaneous EDGE set and clear on the same bit: set wins.
REQ-022 Write to OUT SHALL load wdata[OUT_WIDTH-1:0]; leds update the cycle after we.
REQ-023 Write to MASK SHALL load wdata[IN_WIDTH-1:0]; writes to IN ignored.
REQ-024 rdata SHALL present the addressed register, zero-extended to 32 bits, one cycle after re; rdata holds last value when re low.
REQ-025 Simultaneous we and re to the same register: rdata returns pre-write value.
REQ-026 irq SHALL equal registered |(EDGE & MASK), asserting one cycle after the enabling EDGE bit or MASK write.
REQ-027 Debounce counters SHALL saturate-safe: never exceed DEBOUNCE_VALUE, no wrap.

Reset
REQ-028 On rst: OUT, EDGE, MASK, IN(stable), synchronizers, counters, rdata, irq all 0; leds=0.
REQ-029 Reset asserted mid-debounce SHALL discard pending count; no EDGE set on reset release unless input later debounces high.

Configuration
REQ-030 Macro GPIO_DEBOUNCE_EN defined: debounce per REQ-016..018, REQ-027.
REQ-031 GPIO_DEBOUNCE_EN undefined: stable = synchronizer output, latency 2 cycles, no counters synthesised; DEBOUNCE_* parameters unused.

Verification
REQ-032 Reset then read addr 0..3 -> rdata 0 each; leds=9'b0; irq=0.
REQ-033 Write OUT=0x1A5 -> leds=9'b110100101 next cycle; read OUT -> 0x000001A5.
REQ-034 buttons=8'h01 held (debounce on, value 2) -> IN reads 0x01 after 4 cycles, EDGE bit0 set; 1-cycle pulse 8'h02 -> IN bit1 stays 0.
REQ-035 MASK=0x01, EDGE bit0 set -> irq=1; write EDGE=0x01 -> irq=0 two cycles later.
REQ-036 New rising edge on bit0 in same cycle as EDGE clear write -> EDGE bit0 remains 1, irq stays 1.
REQ-037 Assert rst during debounce count of bit3 -> all outputs 0; after release, input held high debounces in full 4 cycles.
